// File: rtl/pifo_gpfc_pkg.sv
// Shared widths, element field offsets, count-update encoding and the
// overflow-tag rule for the GPFC PIFO calendar controller.
package pifo_gpfc_pkg;

  localparam int ELEMENT_WIDTH_DEF = 19;
  localparam int RANK_WIDTH_DEF    = 17;

  // Packed element layout: {valid, overflow, rank}
  localparam int VALID_BIT = 18;
  localparam int OVF_BIT   = 17;
  localparam int RANK_MSB  = 16;

  // Occupancy update chosen from the accepted requests of one cycle
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A rank at or beyond vtime belongs to the current round; a smaller rank
  // has wrapped and belongs to the next round, so it takes the opposite bit.
  function automatic logic calc_tag(input logic rank_ge_vtime, input logic global_bit);
    calc_tag = rank_ge_vtime ? global_bit : ~global_bit;
  endfunction

endpackage

// File: rtl/pifo_gpfc_rank_tagger.sv
// Combinational rank tagger: compares an incoming rank with the current
// virtual time and packs the valid, round-tagged element for the array.
module pifo_gpfc_rank_tagger
  import pifo_gpfc_pkg::*;
#(
  parameter int ELEMENT_WIDTH      = ELEMENT_WIDTH_DEF,
  parameter int ELEMENT_RANK_WIDTH = RANK_WIDTH_DEF
) (
  input  logic [ELEMENT_RANK_WIDTH-1:0] rank,
  input  logic [ELEMENT_RANK_WIDTH-1:0] vtime,
  input  logic                          global_bit,
  output logic [ELEMENT_WIDTH-1:0]      element
);

  logic rank_ge_s;
  logic tag_s;

  // Unsigned rank/vtime compare, round tag and element packing
  always_comb begin
    rank_ge_s = (rank >= vtime);
    tag_s     = calc_tag(rank_ge_s, global_bit);
    element   = {1'b1, tag_s, rank};
  end

endmodule

// File: rtl/pifo_calendar_gpfc_controller.sv
// GPFC PIFO calendar controller: accepts enqueue/pop requests, issues
// one-cycle insert/pop strobes to the atom array a cycle later, tracks the
// reserved occupancy and advances the virtual time / round bit from the
// popped head element.
module pifo_calendar_gpfc_controller
  import pifo_gpfc_pkg::*;
#(
  parameter int ELEMENT_WIDTH      = ELEMENT_WIDTH_DEF,
  parameter int ELEMENT_RANK_WIDTH = RANK_WIDTH_DEF,
  parameter int DEPTH              = 16,
  parameter int CNT_WIDTH          = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enq_valid,
  input  logic [ELEMENT_RANK_WIDTH-1:0] enq_rank,
  output logic                          enq_ready,
  input  logic                          deq_req,
  output logic                          deq_ready,
  output logic                          deq_valid,
  output logic [ELEMENT_WIDTH-1:0]      deq_element,
  output logic [ELEMENT_WIDTH-1:0]      out_pifo_input,
  output logic                          out_ctl_insert,
  output logic                          out_ctl_pop,
  output logic                          out_global_overflow_bit,
  input  logic [ELEMENT_WIDTH-1:0]      in_head_element,
  output logic [CNT_WIDTH-1:0]          out_count,
  output logic                          out_full,
  output logic                          out_empty
);

  logic [CNT_WIDTH-1:0]          count_r;
  logic [CNT_WIDTH-1:0]          count_nxt_s;
  cnt_op_e                       cnt_op_s;
  logic                          full_s;
  logic                          empty_s;
  logic                          enq_fire_s;
  logic                          deq_fire_s;

  logic                          pend_ins_r;
  logic                          pend_pop_r;
  logic [ELEMENT_RANK_WIDTH-1:0] pend_rank_r;
  logic [ELEMENT_RANK_WIDTH-1:0] vtime_r;
  logic                          global_r;
  logic                          deq_valid_r;
  logic [ELEMENT_WIDTH-1:0]      deq_element_r;
  logic                          err_underrun_r;
  logic [ELEMENT_WIDTH-1:0]      tagged_s;

  // Tag is formed in the strobe cycle from the registered vtime and round bit
  pifo_gpfc_rank_tagger #(
    .ELEMENT_WIDTH      (ELEMENT_WIDTH),
    .ELEMENT_RANK_WIDTH (ELEMENT_RANK_WIDTH)
  ) u_tagger (
    .rank       (pend_rank_r),
    .vtime      (vtime_r),
    .global_bit (global_r),
    .element    (tagged_s)
  );

  // Readiness from the reserved count, held low while in reset; request acceptance
  always_comb begin
    full_s  = (count_r == CNT_WIDTH'(DEPTH));
    empty_s = (count_r == {CNT_WIDTH{1'b0}});
    if (rstn) begin
      enq_ready = ~full_s;
      deq_ready = ~empty_s;
    end else begin
      enq_ready = 1'b0;
      deq_ready = 1'b0;
    end
    enq_fire_s = enq_valid & enq_ready;
    deq_fire_s = deq_req & deq_ready;
  end

  // Occupancy next value: a simultaneous enqueue and pop leave it unchanged
  always_comb begin
    cnt_op_s    = CNT_HOLD;
    count_nxt_s = count_r;
    case ({enq_fire_s, deq_fire_s})
      2'b10:   cnt_op_s = CNT_INC;
      2'b01:   cnt_op_s = CNT_DEC;
      default: cnt_op_s = CNT_HOLD;
    endcase
    case (cnt_op_s)
      CNT_INC:  count_nxt_s = count_r + CNT_WIDTH'(1);
      CNT_DEC:  count_nxt_s = count_r - CNT_WIDTH'(1);
      CNT_HOLD: count_nxt_s = count_r;
      default:  count_nxt_s = count_r;
    endcase
  end

  // Count, pending strobes, pop capture and vtime/round advance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r        <= {CNT_WIDTH{1'b0}};
      pend_ins_r     <= 1'b0;
      pend_pop_r     <= 1'b0;
      pend_rank_r    <= {ELEMENT_RANK_WIDTH{1'b0}};
      vtime_r        <= {ELEMENT_RANK_WIDTH{1'b0}};
      global_r       <= 1'b0;
      deq_valid_r    <= 1'b0;
      deq_element_r  <= {ELEMENT_WIDTH{1'b0}};
      err_underrun_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      pend_ins_r  <= enq_fire_s;
      pend_pop_r  <= deq_fire_s;
      deq_valid_r <= pend_pop_r;
      if (enq_fire_s) begin
        pend_rank_r <= enq_rank;
      end else begin
        pend_rank_r <= pend_rank_r;
      end
      if (pend_pop_r) begin
        deq_element_r <= in_head_element;
        if (in_head_element[VALID_BIT]) begin
          global_r <= in_head_element[OVF_BIT];
          vtime_r  <= in_head_element[RANK_MSB:0];
        end else begin
          // Array underrun: keep vtime/round, remember the event
          err_underrun_r <= 1'b1;
        end
      end else begin
        deq_element_r  <= deq_element_r;
        err_underrun_r <= err_underrun_r;
      end
    end
  end

  // Output mapping; the broadcast element is zero whenever no insert is issued
  always_comb begin
    out_ctl_insert          = pend_ins_r;
    out_ctl_pop             = pend_pop_r;
    out_global_overflow_bit = global_r;
    deq_valid               = deq_valid_r;
    deq_element             = deq_element_r;
    out_count               = count_r;
    out_full                = full_s;
    out_empty               = empty_s;
    if (pend_ins_r) begin
      out_pifo_input = tagged_s;
    end else begin
      out_pifo_input = {ELEMENT_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_pifo_calendar_gpfc_controller.sv
// Self-checking bench for the GPFC PIFO calendar controller: a cycle model
// pushes expected insert/pop elements into queues as requests are accepted,
// and they are popped and compared when the DUT raises its strobes.
module tb_pifo_calendar_gpfc_controller;

  logic        clk;
  logic        rstn;
  logic        enq_valid;
  logic [16:0] enq_rank;
  logic        enq_ready;
  logic        deq_req;
  logic        deq_ready;
  logic        deq_valid;
  logic [18:0] deq_element;
  logic [18:0] out_pifo_input;
  logic        out_ctl_insert;
  logic        out_ctl_pop;
  logic        out_global_overflow_bit;
  logic [18:0] in_head_element;
  logic [4:0]  out_count;
  logic        out_full;
  logic        out_empty;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_count;
  logic [16:0] m_vtime;
  logic        m_global;
  logic        m_ins_now;
  logic        m_pop_now;
  logic        m_dv_now;
  logic        m_rst;
  logic [18:0] exp_ins_q[$];
  logic [18:0] exp_deq_q[$];

  pifo_calendar_gpfc_controller dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .enq_valid               (enq_valid),
    .enq_rank                (enq_rank),
    .enq_ready               (enq_ready),
    .deq_req                 (deq_req),
    .deq_ready               (deq_ready),
    .deq_valid               (deq_valid),
    .deq_element             (deq_element),
    .out_pifo_input          (out_pifo_input),
    .out_ctl_insert          (out_ctl_insert),
    .out_ctl_pop             (out_ctl_pop),
    .out_global_overflow_bit (out_global_overflow_bit),
    .in_head_element         (in_head_element),
    .out_count               (out_count),
    .out_full                (out_full),
    .out_empty               (out_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs seen there
  task automatic model_update();
    logic        e_acc;
    logic        d_acc;
    logic        dv_next;
    logic        tag;
    if (!rstn) begin
      m_count   = 0;
      m_vtime   = 17'd0;
      m_global  = 1'b0;
      m_ins_now = 1'b0;
      m_pop_now = 1'b0;
      m_dv_now  = 1'b0;
      m_rst     = 1'b1;
      exp_ins_q.delete();
      exp_deq_q.delete();
    end else begin
      m_rst   = 1'b0;
      e_acc   = enq_valid && (m_count != 16);
      d_acc   = deq_req && (m_count != 0);
      dv_next = m_pop_now;
      if (m_pop_now) begin
        exp_deq_q.push_back(in_head_element);
        if (in_head_element[18]) begin
          m_global = in_head_element[17];
          m_vtime  = in_head_element[16:0];
        end
      end
      if (e_acc) begin
        tag = (enq_rank >= m_vtime) ? m_global : ~m_global;
        exp_ins_q.push_back({1'b1, tag, enq_rank});
      end
      m_ins_now = e_acc;
      m_pop_now = d_acc;
      m_dv_now  = dv_next;
      if (e_acc && !d_acc) m_count = m_count + 1;
      else if (d_acc && !e_acc) m_count = m_count - 1;
    end
  endtask

  // Compare all observable outputs against the model mid-cycle
  task automatic compare_outputs();
    logic [18:0] exp_e;
    check("enq_ready", enq_ready, rstn && (m_count != 16));
    check("deq_ready", deq_ready, rstn && (m_count != 0));
    check("count", out_count, m_count);
    check("full", out_full, m_count == 16);
    check("empty", out_empty, m_count == 0);
    check("global", out_global_overflow_bit, m_global);
    check("ins_strobe", out_ctl_insert, m_ins_now);
    check("pop_strobe", out_ctl_pop, m_pop_now);
    check("deq_valid", deq_valid, m_dv_now);
    if (out_ctl_insert && m_ins_now) begin
      if (exp_ins_q.size() == 0) check("ins_queue", 1, 0);
      else begin
        exp_e = exp_ins_q.pop_front();
        check("ins_elem", out_pifo_input, exp_e);
      end
    end
    if (deq_valid && m_dv_now) begin
      if (exp_deq_q.size() == 0) check("deq_queue", 1, 0);
      else begin
        exp_e = exp_deq_q.pop_front();
        check("deq_elem", deq_element, exp_e);
      end
    end
    if (m_rst) begin
      check("rst_pifo_input", out_pifo_input, 0);
      check("rst_deq_element", deq_element, 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    enq_valid = 1'b0;
    deq_req   = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic enq_one(input logic [16:0] r);
    enq_valid = 1'b1;
    enq_rank  = r;
    deq_req   = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    enq_valid = 1'b0;
    deq_req   = 1'b1;
    cycle();
  endtask

  initial begin
    rstn            = 1'b0;
    enq_valid       = 1'b0;
    enq_rank        = 17'd0;
    deq_req         = 1'b0;
    in_head_element = 19'd0;
    m_count = 0; m_vtime = 17'd0; m_global = 1'b0;
    m_ins_now = 1'b0; m_pop_now = 1'b0; m_dv_now = 1'b0; m_rst = 1'b0;

    // Reset
    idle(2);
    rstn = 1'b1;
    idle(1);

    // Single enqueue of rank 100
    enq_one(17'd100);
    enq_valid = 1'b0;
    check("r042_insert", out_ctl_insert, 1);
    check("r042_elem", out_pifo_input, 19'h40064);
    check("r042_count", out_count, 1);
    idle(1);

    // Fill to 16 back-to-back, then a held 17th request
    for (int i = 0; i < 15; i++) enq_one(17'($urandom_range(0, 131071)));
    enq_one(17'd55);
    enq_one(17'd56);
    check("r043_full", out_full, 1);
    check("r043_ready", enq_ready, 0);
    idle(2);

    // Pop head {1,0,500}
    in_head_element = 19'h401F4;
    pop_one();
    deq_req = 1'b0;
    check("r044_pop", out_ctl_pop, 1);
    cycle();
    check("r044_dv", deq_valid, 1);
    check("r044_elem", deq_element, 19'h401F4);
    check("r044_global", out_global_overflow_bit, 0);
    for (int i = 0; i < 3; i++) pop_one();
    idle(2);

    // Tags relative to vtime=500, global=0
    enq_one(17'd20);
    check("r045_a", out_pifo_input, 19'h60014);
    enq_one(17'd600);
    check("r045_b", out_pifo_input, 19'h40258);
    idle(2);

    // Drain to 3, then a simultaneous enqueue and pop
    for (int i = 0; i < 11; i++) pop_one();
    idle(2);
    enq_valid = 1'b1; enq_rank = 17'd7; deq_req = 1'b1;
    cycle();
    enq_valid = 1'b0; deq_req = 1'b0;
    check("r046_ins", out_ctl_insert, 1);
    check("r046_pop", out_ctl_pop, 1);
    check("r046_count", out_count, 3);
    idle(2);

    // Underrun pop, then a next-round head
    in_head_element = 19'h01234;
    pop_one();
    idle(2);
    in_head_element = 19'h6012C;
    pop_one();
    idle(2);
    check("round_global", out_global_overflow_bit, 1);
    enq_one(17'd400);
    enq_one(17'd10);
    idle(2);

    // Drain to empty, pops at empty ignored, enqueue+pop at empty
    for (int i = 0; i < 4; i++) pop_one();
    idle(1);
    enq_valid = 1'b1; enq_rank = 17'd3; deq_req = 1'b1;
    cycle();
    enq_valid = 1'b0;
    check("r034_no_pop", out_ctl_pop, 0);
    cycle();
    deq_req = 1'b0;
    idle(2);

    // Insert strobe in flight when reset asserts
    enq_one(17'd77);
    enq_valid = 1'b0;
    rstn = 1'b0;
    cycle();
    check("r047_ready", enq_ready, 0);
    check("r047_count", out_count, 0);
    rstn = 1'b1;
    cycle();
    check("r047_no_strobe", out_ctl_insert, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      enq_valid       = ($urandom_range(0, 99) < 55);
      enq_rank        = 17'($urandom_range(0, 131071));
      deq_req         = ($urandom_range(0, 99) < 50);
      in_head_element = {($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                         17'($urandom_range(0, 131071))};
      cycle();
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
